// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-only data memory (byte/half/word loads, RMW sub-word stores).
// Define MAU_MISALIGN_CHECK_EN to reject misaligned half/word requests with resp_err.
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
    state_t state;
    logic        sgn, err, misalign;
    logic [1:0]  size, lane;
    logic [31:0] wdata, ld_data, bmask, hmask, merged;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    logic        unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign resp_err = err;
`ifdef MAU_MISALIGN_CHECK_EN
    assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    // half lanes use only lane[1], word uses neither, so low bits are masked implicitly
    always_comb begin
        rd_b    = 8'(mem_rdata >> {lane, 3'b000});
        rd_h    = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = size == 2'b00 ? {{24{sgn & rd_b[7]}}, rd_b}
                : size == 2'b01 ? {{16{sgn & rd_h[15]}}, rd_h} : mem_rdata;
        bmask   = 32'h0000_00ff << {lane, 3'b000};
        hmask   = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
        merged  = size == 2'b00 ? (mem_rdata & ~bmask) | ({4{wdata[7:0]}} & bmask)
                                : (mem_rdata & ~hmask) | ({2{wdata[15:0]}} & hmask);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            err         <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    sgn         <= req_signed;
                    size        <= req_size;
                    lane        <= req_addr[1:0];
                    wdata       <= req_wdata;
                    err         <= misalign;
                    req_ready   <= 1'b0;
                    mem_address <= {{(30 - ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                    if (misalign) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else if (!req_write) begin
                        state    <= LOAD;
                        mem_read <= 1'b1;
                    end else if (req_size[1]) begin
                        state     <= STORE;
                        mem_write <= 1'b1;
                        mem_wdata <= req_wdata;
                    end else begin
                        state    <= RMW_RD;
                        mem_read <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    mem_read   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_data;
                end
                RMW_RD: begin
                    state     <= RMW_WR;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= merged;
                end
                STORE, RMW_WR: begin
                    state      <= RESP;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end
endmodule
